// File: rtl/mdio_phy_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_phy_resp
// Brief    : Clause-22 MDIO responder standing in for an external PHY.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_phy_resp #(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1622
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic        o_wr_vld,
  output logic [4:0]  o_wr_addr,
  output logic [15:0] o_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mdc_s1, r_mdc_s2, r_mdc_d, r_mdio_s1, r_mdio_s2;
  logic        w_rise, w_fall, w_bit, w_step, w_drive, w_last_addr_bit;
  logic        w_writable, w_wr_fire;
  logic [4:0]  w_addr_full;
  logic [15:0] w_rd_val, w_wr_data;
  logic [5:0]  r_pre_cnt;
  logic [4:0]  r_bit_cnt, r_regad;
  logic [3:0]  r_addr_sr;
  logic        r_op_msb, r_is_read, r_match;
  logic [15:0] r_sr;
  logic [14:0] r_reg0;
  logic [15:0] r_reg4, r_reg31;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdc_s1  <= 1'b0;
      r_mdc_s2  <= 1'b0;
      r_mdc_d   <= 1'b0;
      r_mdio_s1 <= 1'b1;
      r_mdio_s2 <= 1'b1;
    end else begin
      r_mdc_s1  <= i_mdc;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_d   <= r_mdc_s2;
      r_mdio_s1 <= i_mdio;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  assign w_rise          = r_mdc_s2 & ~r_mdc_d;
  assign w_fall          = ~r_mdc_s2 & r_mdc_d;
  assign w_bit           = r_mdio_s2;
  assign w_drive         = r_is_read & r_match;
  assign w_addr_full     = {r_addr_sr, w_bit};
  assign w_last_addr_bit = (r_bit_cnt == 5'd4);
  assign w_wr_data       = {r_sr[14:0], w_bit};
  assign w_writable      = (r_regad == 5'd0) || (r_regad == 5'd4) || (r_regad == 5'd31);
  assign w_wr_fire       = (r_state == S_DATA) && !r_is_read && r_match && w_rise &&
                           (r_bit_cnt == 5'd15) && w_writable;
  // A matched read is clocked by MDC falls once it reaches turnaround; all else by rises.
  assign w_step          = (w_drive && (r_state == S_TA || r_state == S_DATA)) ? w_fall : w_rise;

  always_comb begin
    w_rd_val = 16'h0000;
    case (w_addr_full)
      5'd0:    w_rd_val = {1'b0, r_reg0};
      5'd1:    w_rd_val = 16'h786D;
      5'd2:    w_rd_val = PHY_ID1;
      5'd3:    w_rd_val = PHY_ID2;
      5'd4:    w_rd_val = r_reg4;
      5'd31:   w_rd_val = r_reg31;
      default: w_rd_val = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise && !w_bit && r_pre_cnt[5]) w_state_nxt = S_ST;
      S_ST:    if (w_rise) w_state_nxt = w_bit ? S_OP : S_IDLE;
      S_OP:    if (w_rise && r_bit_cnt[0])
                 w_state_nxt = (r_op_msb != w_bit) ? S_PHYAD : S_IDLE;
      S_PHYAD: if (w_rise && w_last_addr_bit) w_state_nxt = S_REGAD;
      S_REGAD: if (w_rise && w_last_addr_bit) w_state_nxt = S_TA;
      S_TA: begin
        if (w_drive) begin
          if (w_fall && r_bit_cnt == 5'd2) w_state_nxt = S_DATA;
        end else if (w_rise && r_bit_cnt[0]) begin
          w_state_nxt = (!r_is_read && w_bit) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_drive) begin
          if (w_fall && r_bit_cnt == 5'd16) w_state_nxt = S_IDLE;
        end else if (w_rise && r_bit_cnt == 5'd15) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 5'd0;
      r_regad   <= 5'd0;
      r_addr_sr <= 4'd0;
      r_op_msb  <= 1'b0;
      r_is_read <= 1'b0;
      r_match   <= 1'b0;
      r_sr      <= 16'h0000;
      r_reg0    <= 15'h1140;
      r_reg4    <= 16'h01E1;
      r_reg31   <= 16'h0000;
      o_mdio    <= 1'b1;
      o_mdio_oe <= 1'b0;
      o_wr_vld  <= 1'b0;
      o_wr_addr <= 5'd0;
      o_wr_data <= 16'h0000;
    end else begin
      o_wr_vld <= 1'b0;

      if (r_state == S_TA && w_state_nxt == S_DATA && w_drive) r_bit_cnt <= 5'd1;
      else if (w_state_nxt != r_state)                          r_bit_cnt <= 5'd0;
      else if (w_step)                                          r_bit_cnt <= r_bit_cnt + 5'd1;

      if (r_state != S_IDLE) r_pre_cnt <= 6'd0;
      else if (w_rise) begin
        if (!w_bit)                  r_pre_cnt <= 6'd0;
        else if (r_pre_cnt != 6'd63) r_pre_cnt <= r_pre_cnt + 6'd1;
      end

      if (r_state == S_OP && w_rise) begin
        if (!r_bit_cnt[0]) r_op_msb  <= w_bit;
        else               r_is_read <= r_op_msb;
      end

      if ((r_state == S_PHYAD || r_state == S_REGAD) && w_rise) begin
        r_addr_sr <= w_addr_full[3:0];
        if (w_last_addr_bit) begin
          if (r_state == S_PHYAD) r_match <= (w_addr_full == PHY_ADDR);
          else begin
            r_regad <= w_addr_full;
            if (w_drive) r_sr <= w_rd_val;
          end
        end
      end

      if (r_state == S_TA && w_drive && w_fall) begin
        if (r_bit_cnt == 5'd0) o_mdio_oe <= 1'b0;
        else if (r_bit_cnt == 5'd1) begin
          o_mdio_oe <= 1'b1;
          o_mdio    <= 1'b0;
        end else begin
          o_mdio_oe <= 1'b1;
          o_mdio    <= r_sr[15];
          r_sr      <= {r_sr[14:0], 1'b0};
        end
      end

      if (r_state == S_DATA && w_drive && w_fall) begin
        if (r_bit_cnt == 5'd16) begin
          o_mdio_oe <= 1'b0;
          o_mdio    <= 1'b1;
        end else begin
          o_mdio <= r_sr[15];
          r_sr   <= {r_sr[14:0], 1'b0};
        end
      end

      if (r_state == S_DATA && !w_drive && w_rise) r_sr <= w_wr_data;

      if (w_wr_fire) begin
        case (r_regad)
          5'd0:    r_reg0  <= w_wr_data[14:0];
          5'd4:    r_reg4  <= w_wr_data;
          default: r_reg31 <= w_wr_data;
        endcase
        o_wr_vld  <= 1'b1;
        o_wr_addr <= r_regad;
        o_wr_data <= w_wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_phy_resp
// Brief    : Directed table plus random frames against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_phy_resp;

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
    logic        exp_resp;
    logic [15:0] exp_rd;
    logic        exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc, mac_oe, mac_bit;
  logic        mdio_line;
  logic        o_mdio, o_mdio_oe, o_wr_vld;
  logic [4:0]  o_wr_addr;
  logic [15:0] o_wr_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  logic [4:0]  wr_addr_seen;
  logic [15:0] wr_data_seen;
  logic [15:0] m_reg0, m_reg4, m_reg31;
  vec_t        tbl[16];

  always #5 clk = ~clk;

  // Pull-up on the shared line when nobody drives it.
  assign mdio_line = o_mdio_oe ? o_mdio : (mac_oe ? mac_bit : 1'b1);

  mdio_phy_resp #(.PHY_ADDR(5'd0), .PHY_ID1(16'h0022), .PHY_ID2(16'h1622)) dut (
    .clk(clk), .reset(reset), .i_mdc(mdc), .i_mdio(mdio_line),
    .o_mdio(o_mdio), .o_mdio_oe(o_mdio_oe), .o_wr_vld(o_wr_vld),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always @(negedge clk) begin
    if (o_wr_vld) begin
      wr_cnt++;
      wr_addr_seen = o_wr_addr;
      wr_data_seen = o_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One MDC period of 10 clk; the line is sampled as the MAC would, at the rise.
  task automatic mdc_cycle(input logic drive, input logic b, output logic s_oe, output logic s_line);
    mac_oe  = drive;
    mac_bit = b;
    mdc     = 1'b0;
    repeat (5) @(negedge clk);
    mdc    = 1'b1;
    s_oe   = o_mdio_oe;
    s_line = mdio_line;
    repeat (5) @(negedge clk);
  endtask

  function automatic vec_t mk(int pre, logic [1:0] op, logic [4:0] phy, logic [4:0] regad,
                              logic [1:0] ta, logic [15:0] data, logic er, logic [15:0] rd, logic ew);
    vec_t v;
    v.pre = pre; v.op = op; v.phy = phy; v.regad = regad; v.ta = ta; v.data = data;
    v.exp_resp = er; v.exp_rd = rd; v.exp_wr = ew;
    return v;
  endfunction

  task automatic send_header(input vec_t v);
    logic so, sl;
    logic [13:0] hdr;
    hdr = {2'b01, v.op, v.phy, v.regad};
    mdc_cycle(1'b1, 1'b0, so, sl);
    for (int i = 0; i < v.pre; i++) mdc_cycle(1'b1, 1'b1, so, sl);
    for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], so, sl);
  endtask

  task automatic run_frame(input vec_t v);
    logic so, sl, t1_oe, t2_oe, t2_line, rel_oe, oe_all, any_oe;
    logic [15:0] rd;
    int wr0;
    wr0    = wr_cnt;
    oe_all = 1'b1;
    any_oe = 1'b0;
    rd     = 16'h0;
    send_header(v);
    if (v.op == 2'b10) begin
      mdc_cycle(1'b0, 1'b1, t1_oe, sl);
      mdc_cycle(1'b0, 1'b1, t2_oe, t2_line);
      for (int i = 0; i < 16; i++) begin
        mdc_cycle(1'b0, 1'b1, so, sl);
        rd     = {rd[14:0], sl};
        oe_all = oe_all & so;
        any_oe = any_oe | so;
      end
      mdc_cycle(1'b0, 1'b1, rel_oe, sl);
      if (v.exp_resp) begin
        chk("ta_z", {31'd0, t1_oe}, 32'd0);
        chk("ta_zero", {30'd0, t2_oe, t2_line}, 32'd2);
        chk("rd_data", {16'd0, rd}, {16'd0, v.exp_rd});
        chk("data_oe", {31'd0, oe_all}, 32'd1);
        chk("release", {31'd0, rel_oe}, 32'd0);
      end else begin
        chk("passive", {31'd0, any_oe | t1_oe | t2_oe | rel_oe}, 32'd0);
      end
    end else begin
      mdc_cycle(1'b1, v.ta[1], so, sl);
      any_oe = any_oe | so;
      mdc_cycle(1'b1, v.ta[0], so, sl);
      any_oe = any_oe | so;
      for (int i = 15; i >= 0; i--) begin
        mdc_cycle(1'b1, v.data[i], so, sl);
        any_oe = any_oe | so;
      end
      mdc_cycle(1'b1, 1'b1, so, sl);
      chk("wr_passive", {31'd0, any_oe | so}, 32'd0);
      chk("wr_pulses", wr_cnt - wr0, v.exp_wr ? 32'd1 : 32'd0);
      if (v.exp_wr) begin
        chk("wr_addr", {27'd0, wr_addr_seen}, {27'd0, v.regad});
        chk("wr_data", {16'd0, wr_data_seen}, {16'd0, v.data});
      end
    end
  endtask

  function automatic logic [15:0] model_read(logic [4:0] a);
    case (a)
      5'd0:    return m_reg0;
      5'd1:    return 16'h786D;
      5'd2:    return 16'h0022;
      5'd3:    return 16'h1622;
      5'd4:    return m_reg4;
      5'd31:   return m_reg31;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_reg0  = 16'h1140;
    m_reg4  = 16'h01E1;
    m_reg31 = 16'h0000;
  endtask

  initial begin : main
    logic so, sl;
    logic [13:0] hdr;
    vec_t v;
    logic valid, wok;
    int r;
    logic [4:0] reg_pick[6];
    reg_pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31};

    reset = 1'b1; mdc = 1'b0; mac_oe = 1'b1; mac_bit = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_state", {o_mdio_oe, o_mdio, o_wr_vld, o_wr_addr, o_wr_data}, {3'b010, 5'd0, 16'h0});
    reset = 1'b0;
    repeat (4) @(negedge clk);

    tbl[0]  = mk(32, 2'b10, 5'd0, 5'd2,  2'b10, 16'h0000, 1'b1, 16'h0022, 1'b0);
    tbl[1]  = mk(32, 2'b01, 5'd0, 5'd4,  2'b10, 16'hABCD, 1'b0, 16'h0000, 1'b1);
    tbl[2]  = mk(32, 2'b10, 5'd0, 5'd4,  2'b10, 16'h0000, 1'b1, 16'hABCD, 1'b0);
    tbl[3]  = mk(32, 2'b10, 5'd5, 5'd1,  2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[4]  = mk(32, 2'b10, 5'd0, 5'd1,  2'b10, 16'h0000, 1'b1, 16'h786D, 1'b0);
    tbl[5]  = mk(31, 2'b10, 5'd0, 5'd2,  2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[6]  = mk(32, 2'b10, 5'd0, 5'd2,  2'b10, 16'h0000, 1'b1, 16'h0022, 1'b0);
    tbl[7]  = mk(32, 2'b01, 5'd0, 5'd0,  2'b10, 16'h9200, 1'b0, 16'h0000, 1'b1);
    tbl[8]  = mk(32, 2'b01, 5'd0, 5'd1,  2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tbl[9]  = mk(32, 2'b10, 5'd0, 5'd0,  2'b10, 16'h0000, 1'b1, 16'h1200, 1'b0);
    tbl[10] = mk(32, 2'b10, 5'd0, 5'd1,  2'b10, 16'h0000, 1'b1, 16'h786D, 1'b0);
    tbl[11] = mk(32, 2'b01, 5'd0, 5'd31, 2'b11, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
    tbl[12] = mk(32, 2'b10, 5'd0, 5'd31, 2'b10, 16'h0000, 1'b1, 16'h0000, 1'b0);
    tbl[13] = mk(33, 2'b10, 5'd0, 5'd3,  2'b10, 16'h0000, 1'b1, 16'h1622, 1'b0);
    tbl[14] = mk(32, 2'b01, 5'd0, 5'd31, 2'b10, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    tbl[15] = mk(32, 2'b10, 5'd0, 5'd31, 2'b10, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 16; i++) run_frame(tbl[i]);

    // Reset partway through the data phase of a read of reg2.
    v = mk(32, 2'b10, 5'd0, 5'd2, 2'b10, 16'h0, 1'b1, 16'h0022, 1'b0);
    send_header(v);
    for (int i = 0; i < 7; i++) mdc_cycle(1'b0, 1'b1, so, sl);
    mac_oe = 1'b0;
    mdc    = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_oe", {31'd0, o_mdio_oe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_release", {30'd0, o_mdio_oe, o_mdio}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    run_frame(mk(32, 2'b10, 5'd0, 5'd4, 2'b10, 16'h0, 1'b1, 16'h01E1, 1'b0));
    run_frame(mk(32, 2'b10, 5'd0, 5'd0, 2'b10, 16'h0, 1'b1, 16'h1140, 1'b0));

    for (int n = 0; n < 30; n++) begin
      v.pre   = ($urandom_range(0, 7) == 0) ? 31 : 32 + int'($urandom_range(0, 3));
      r       = int'($urandom_range(0, 9));
      v.op    = (r < 5) ? 2'b10 : (r < 9) ? 2'b01 : 2'b00;
      v.phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      v.regad = ($urandom_range(0, 6) == 6) ? 5'($urandom_range(0, 31))
                                            : reg_pick[$urandom_range(0, 5)];
      v.ta    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
      v.data  = 16'($urandom);
      valid      = (v.pre >= 32) && (v.op == 2'b10 || v.op == 2'b01) && (v.phy == 5'd0);
      v.exp_resp = valid && (v.op == 2'b10);
      v.exp_rd   = model_read(v.regad);
      wok        = (v.regad == 5'd0) || (v.regad == 5'd4) || (v.regad == 5'd31);
      v.exp_wr   = valid && (v.op == 2'b01) && (v.ta[0] == 1'b0) && wok;
      run_frame(v);
      if (v.exp_wr) begin
        if (v.regad == 5'd0)      m_reg0  = {1'b0, v.data[14:0]};
        else if (v.regad == 5'd4) m_reg4  = v.data;
        else                      m_reg31 = v.data;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
